// File: rtl/neuron_result_collector.sv
// Collects one frame of signed neuron outputs and reports the argmax.
// Define COLLECT_READBACK_EN to keep a per-frame output buffer with readback.
module neuron_result_collector #(
  parameter int DATA_W    = 16,
  parameter int N_NEURONS = 10,
  parameter int IDX_W     = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              res_valid,
  output logic [IDX_W-1:0]  res_idx,
  output logic [DATA_W-1:0] res_max,
  input  logic              res_ack,
  output logic              busy
`ifdef COLLECT_READBACK_EN
  ,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_RESULT  = 2'd2;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_NEURONS - 1);

  logic [1:0]       state;
  logic [IDX_W-1:0] count;
  logic             accept;
  logic             is_last;
  logic             take_max;

  assign in_ready = (state == S_COLLECT);

  // start wins over a same-cycle beat
  assign accept  = in_ready & in_valid & ~start;
  assign is_last = (count == LAST);

  assign take_max = (count == '0) ||
                    ($signed(in_data) > $signed(res_max));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      count     <= '0;
      res_idx   <= '0;
      res_max   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_COLLECT;
            busy  <= 1'b1;
            count <= '0;
          end
        end
        S_COLLECT: begin
          if (start) begin
            count   <= '0;
            res_idx <= '0;
            res_max <= '0;
          end else if (accept) begin
            if (take_max) begin
              res_max <= in_data;
              res_idx <= count;
            end
            if (is_last) begin
              state     <= S_RESULT;
              res_valid <= 1'b1;
              count     <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
        end
        S_RESULT: begin
          if (res_ack) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
          count     <= '0;
        end
      endcase
    end
  end

`ifdef COLLECT_READBACK_EN
  logic [DATA_W-1:0] mem [N_NEURONS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_NEURONS; i++)
        mem[i] <= '0;
    end else if (accept) begin
      mem[count] <= in_data;
    end
  end

  always_comb begin
    rd_data = '0;
    if (int'(rd_addr) < N_NEURONS)
      rd_data = mem[rd_addr];
  end
`endif

endmodule

// File: tb/tb_neuron_result_collector.sv
// Randomized bench for neuron_result_collector with an argmax reference model.
// Readback checks are built when COLLECT_READBACK_EN is defined.
module tb_neuron_result_collector;

  localparam int DW = 16;
  localparam int N  = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          res_ack = 1'b0;
  logic          in_ready;
  logic          res_valid;
  logic [IW-1:0] res_idx;
  logic [DW-1:0] res_max;
  logic          busy;
`ifdef COLLECT_READBACK_EN
  logic [IW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
`endif

  int checks = 0;
  int failures = 0;

  logic signed [DW-1:0] frame [N];
  logic signed [DW-1:0] stored [N];

  neuron_result_collector #(
    .DATA_W(DW), .N_NEURONS(N), .IDX_W(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .res_valid(res_valid),
    .res_idx(res_idx),
    .res_max(res_max),
    .res_ack(res_ack),
    .busy(busy)
`ifdef COLLECT_READBACK_EN
    ,
    .rd_addr(rd_addr),
    .rd_data(rd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Reference: first index holding the largest signed value.
  task automatic model(output int idx, output logic [DW-1:0] mx);
    int best;
    best = 0;
    for (int i = 1; i < N; i++)
      if (int'(frame[i]) > int'(frame[best]))
        best = i;
    idx = best;
    mx  = frame[best];
  endtask

  task automatic feed(input int max_gap);
    for (int i = 0; i < N; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
        step();
      end
      if (i == N - 1)
        check("valid_before_last", res_valid, 0);
      in_valid = 1'b1;
      in_data  = frame[i];
      step();
      in_valid = 1'b0;
    end
  endtask

  task automatic readback(input string tag);
`ifdef COLLECT_READBACK_EN
    for (int a = 0; a < N; a++) begin
      rd_addr = IW'(a);
      #1;
      check({tag, "_rd"}, rd_data, stored[a]);
    end
    rd_addr = IW'(12);
    #1;
    check({tag, "_rd_oob"}, rd_data, 0);
`else
    if (tag.len() < 0) check(tag, 0, 1);
`endif
  endtask

  task automatic run_frame(input string tag, input int max_gap);
    int            e_idx;
    logic [DW-1:0] e_max;
    pulse_start();
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready"}, in_ready, 1);
    feed(max_gap);
    model(e_idx, e_max);
    for (int i = 0; i < N; i++) stored[i] = frame[i];
    check({tag, "_valid"}, res_valid, 1);
    check({tag, "_ready_res"}, in_ready, 0);
    check({tag, "_idx"}, res_idx, e_idx);
    check({tag, "_max"}, res_max, e_max);
    repeat (3) begin
      start = $urandom_range(0, 1) == 1;
      in_valid = 1'b1;
      in_data = 16'h7fff;
      step();
      check({tag, "_hold_v"}, res_valid, 1);
      check({tag, "_hold_i"}, res_idx, e_idx);
      check({tag, "_hold_m"}, res_max, e_max);
    end
    in_valid = 1'b0;
    res_ack = 1'b1;
    start = 1'b1;
    step();
    res_ack = 1'b0;
    start = 1'b0;
    check({tag, "_ack_v"}, res_valid, 0);
    check({tag, "_ack_busy"}, busy, 0);
    step();
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_ready"}, in_ready, 0);
    check({tag, "_kept_i"}, res_idx, e_idx);
    check({tag, "_kept_m"}, res_max, e_max);
    readback(tag);
  endtask

  task automatic set_frame(input int v0, v1, v2, v3, v4,
                           input int v5, v6, v7, v8, v9);
    frame[0] = DW'(v0); frame[1] = DW'(v1);
    frame[2] = DW'(v2); frame[3] = DW'(v3);
    frame[4] = DW'(v4); frame[5] = DW'(v5);
    frame[6] = DW'(v6); frame[7] = DW'(v7);
    frame[8] = DW'(v8); frame[9] = DW'(v9);
  endtask

  initial begin
    step();
    check("rst_ready", in_ready, 0);
    check("rst_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_idx", res_idx, 0);
    check("rst_max", res_max, 0);
    rst = 1'b1;
    step();

    // reset in the middle of a frame
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = DW'(20 + i);
      step();
    end
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("abort_ready", in_ready, 0);
    check("abort_valid", res_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_max", res_max, 0);
    step();
    rst = 1'b1;
    step();
    check("post_abort_busy", busy, 0);
    for (int i = 0; i < N; i++) stored[i] = '0;
    readback("rst_buf");

    set_frame(3, -7, 12, 5, 0, 1, 2, 4, 9, 8);
    run_frame("basic", 0);
    set_frame(-5, -2, -9, -4, -8, -6, -7, -10, -11, -3);
    run_frame("neg", 1);
    for (int i = 0; i < N; i++) frame[i] = 16'sd7;
    run_frame("tie", 3);

    // restart after four beats; discarded beat during start
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = 16'sd30000;
      step();
    end
    start = 1'b1;
    in_valid = 1'b1;
    in_data = 16'h7fff;
    step();
    start = 1'b0;
    in_valid = 1'b0;
    check("restart_max", res_max, 0);
    check("restart_busy", busy, 1);
    set_frame(1, 2, 3, 4, 5, 6, 7, 8, 100, 9);
    feed(1);
    check("restart_valid", res_valid, 1);
    check("restart_idx", res_idx, 8);
    check("restart_val", res_max, 100);
    res_ack = 1'b1;
    step();
    res_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data = 16'h7fff;
      step();
      check("idle_ready", in_ready, 0);
      check("idle_busy", busy, 0);
      check("idle_max", res_max, 100);
    end
    in_valid = 1'b0;

    for (int f = 0; f < 20; f++) begin
      for (int i = 0; i < N; i++)
        if (f % 2 == 0) frame[i] = DW'($urandom);
        else frame[i] = DW'($urandom_range(0, 7) - 4);
      run_frame("rand", f % 4);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
